ebox_mbox_req: RTL and testbench

Memory-request sequencer directly downstream of the EBOX. It latches each EBOX memory request (EBOX_REQ, EBOX_VMA, eboxRead/eboxWrite/eboxPSE, cacheDataWrite) and runs the request/acknowledge/data handshake with the MBOX memory port. It returns read data, completion, retry and error indications to the EBOX (cacheDataRead, mboxRespIn, cshEBOXRetry, mbParErr, nxmErr). It also owns the read-pause-write hold, parity-error retry and the non-existent-memory timeout.

---
 rtl/ebox_mem_pkg.sv | 26 ++
 rtl/mem_req_timer.sv | 49 ++++
 rtl/ebox_mbox_req.sv | 222 ++++++++++++++++++++++
 tb/tb_ebox_mbox_req.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebox_mem_pkg.sv
// ----------------------------------------------------------------------------
// ebox_mem_pkg
// Types and default constants shared by the EBOX memory-request sequencer and
// the later EBUS transfer logic.
//   tMemReqState : sequencer states
//   tVMA         : virtual memory address, PDP-10 bit numbering [13:35]
//   tWord        : 36-bit data word, PDP-10 bit numbering [0:35]
// ----------------------------------------------------------------------------
package ebox_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        PAUSE  = 2'd3
    } tMemReqState;

    typedef logic [13:35] tVMA;
    typedef logic [0:35]  tWord;

    // Cycles memReq may stay unacknowledged before NXM is declared.
    localparam int MEM_TIMEOUT_CYC = 64;
    // Read parity-error retries before the error is reported to the EBOX.
    localparam int MEM_RETRY_MAX   = 3;

endpackage

// File: rtl/mem_req_timer.sv
// ----------------------------------------------------------------------------
// mem_req_timer
// 8-bit saturating cycle counter used to detect a memory port that never
// answers. Clear has priority over enable.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   clr_i   : synchronous clear to zero
//   en_i    : count this cycle
//   tc_o    : count has reached TC_VAL (stays high until cleared)
// ----------------------------------------------------------------------------
module mem_req_timer #(
    parameter logic [7:0] TC_VAL = 8'd63
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Greater-or-equal so a count that ran past the terminal value while
    // another event had priority still times out on the following cycle.
    assign tc_o = (cnt_q >= TC_VAL);

endmodule

// File: rtl/ebox_mbox_req.sv
// ----------------------------------------------------------------------------
// ebox_mbox_req
// Memory-request sequencer between the EBOX and the MBOX memory port.
// Latches an EBOX request, runs the memReq/memAck/memRdValid handshake,
// retries reads that return bad parity, declares NXM when the port does not
// answer, and supports read-pause-write (address held across the pause).
// Inputs : eboxClk, eboxResetN, EBOX_REQ, EBOX_VMA, eboxRead, eboxWrite,
//          eboxPSE, cacheDataWrite, memAck, memRdValid, memRdData,
//          memRdParErr
// Outputs: memReq, memAdr, memWr, memWrData (to MBOX); cacheDataRead,
//          mboxRespIn, cshEBOXRetry, mbParErr, nxmErr, mboxBusy (to EBOX).
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module ebox_mbox_req
    import ebox_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = MEM_TIMEOUT_CYC,
    parameter int RETRY_MAX   = MEM_RETRY_MAX
) (
    input  logic         eboxClk,
    input  logic         eboxResetN,
    input  logic         EBOX_REQ,
    input  logic [13:35] EBOX_VMA,
    input  logic         eboxRead,
    input  logic         eboxWrite,
    input  logic         eboxPSE,
    input  logic [0:35]  cacheDataWrite,
    input  logic         memAck,
    input  logic         memRdValid,
    input  logic [0:35]  memRdData,
    input  logic         memRdParErr,
    output logic         memReq,
    output logic [13:35] memAdr,
    output logic         memWr,
    output logic [0:35]  memWrData,
    output logic [0:35]  cacheDataRead,
    output logic         mboxRespIn,
    output logic         cshEBOXRetry,
    output logic         mbParErr,
    output logic         nxmErr,
    output logic         mboxBusy
);

    // Timer terminal value is one less than the limit: the count is zero in
    // the first memReq cycle, so TIMEOUT_CYC-1 marks the last allowed cycle.
    localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT_CYC - 1);
    localparam logic [2:0] RETRY_LIM  = 3'(RETRY_MAX);

    tMemReqState state_q, state_d;
    tVMA         adr_q, adr_d;
    tWord        wdat_q, wdat_d;
    tWord        rdata_q, rdata_d;
    logic        wr_q, wr_d;
    logic        pse_q, pse_d;
    logic [2:0]  retry_cnt_q, retry_cnt_d;
    logic        resp_q, resp_d;
    logic        retry_pls_q, retry_pls_d;
    logic        parerr_q, parerr_d;
    logic        nxm_q, nxm_d;
    logic        memreq_q, memreq_d;
    logic        busy_q, busy_d;

    logic        tmr_clr_s;
    logic        tmr_en_s;
    logic        tmr_tc_s;

    mem_req_timer #(
        .TC_VAL (TIMEOUT_TC)
    ) u_timer (
        .clk_i  (eboxClk),
        .rst_ni (eboxResetN),
        .clr_i  (tmr_clr_s),
        .en_i   (tmr_en_s),
        .tc_o   (tmr_tc_s)
    );

    // Next-state, request latching and response-pulse decode.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        wr_d        = wr_q;
        pse_d       = pse_q;
        rdata_d     = rdata_q;
        retry_cnt_d = retry_cnt_q;
        resp_d      = 1'b0;
        retry_pls_d = 1'b0;
        parerr_d    = 1'b0;
        nxm_d       = 1'b0;
        tmr_clr_s   = 1'b0;
        tmr_en_s    = 1'b0;

        case (state_q)
            IDLE, PAUSE: begin
                tmr_clr_s = 1'b1;
                if (EBOX_REQ && (state_q == PAUSE) && eboxWrite) begin
                    // Write half of read-pause-write: the paused address is
                    // kept and EBOX_VMA is ignored.
                    wdat_d      = cacheDataWrite;
                    wr_d        = 1'b1;
                    pse_d       = 1'b0;
                    retry_cnt_d = 3'd0;
                    state_d     = ISSUE;
                end else if (EBOX_REQ && (eboxRead || eboxWrite)) begin
                    // Fresh request; a read arriving in PAUSE abandons it.
                    adr_d       = EBOX_VMA;
                    wdat_d      = cacheDataWrite;
                    wr_d        = eboxWrite & ~eboxRead;
                    pse_d       = eboxRead & eboxPSE;
                    retry_cnt_d = 3'd0;
                    state_d     = ISSUE;
                end else begin
                    state_d = state_q;
                end
            end

            ISSUE: begin
                tmr_en_s = 1'b1;
                if (memAck) begin
                    // Ack beats a simultaneous terminal count.
                    if (wr_q) begin
                        resp_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RDWAIT;
                    end
                end else if (tmr_tc_s) begin
                    nxm_d   = 1'b1;
                    resp_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = ISSUE;
                end
            end

            RDWAIT: begin
                // memAck is deliberately not looked at here.
                tmr_en_s = 1'b1;
                if (memRdValid) begin
                    if (!memRdParErr) begin
                        rdata_d     = memRdData;
                        resp_d      = 1'b1;
                        retry_cnt_d = 3'd0;
                        state_d     = pse_q ? PAUSE : IDLE;
                    end else if (retry_cnt_q < RETRY_LIM) begin
                        // Reissue the same address with a fresh timeout.
                        retry_cnt_d = retry_cnt_q + 3'd1;
                        retry_pls_d = 1'b1;
                        tmr_clr_s   = 1'b1;
                        state_d     = ISSUE;
                    end else begin
                        // Out of retries: hand the bad word over and flag it.
                        rdata_d     = memRdData;
                        parerr_d    = 1'b1;
                        resp_d      = 1'b1;
                        retry_cnt_d = 3'd0;
                        state_d     = IDLE;
                    end
                end else if (tmr_tc_s) begin
                    nxm_d   = 1'b1;
                    resp_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RDWAIT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered from the next state so memReq/mboxBusy line up with it.
        memreq_d = (state_d == ISSUE);
        busy_d   = (state_d == ISSUE) || (state_d == RDWAIT);
    end

    // State, datapath and output registers.
    always_ff @(posedge eboxClk or negedge eboxResetN) begin
        if (!eboxResetN) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            wdat_q      <= '0;
            rdata_q     <= '0;
            wr_q        <= 1'b0;
            pse_q       <= 1'b0;
            retry_cnt_q <= 3'd0;
            resp_q      <= 1'b0;
            retry_pls_q <= 1'b0;
            parerr_q    <= 1'b0;
            nxm_q       <= 1'b0;
            memreq_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            rdata_q     <= rdata_d;
            wr_q        <= wr_d;
            pse_q       <= pse_d;
            retry_cnt_q <= retry_cnt_d;
            resp_q      <= resp_d;
            retry_pls_q <= retry_pls_d;
            parerr_q    <= parerr_d;
            nxm_q       <= nxm_d;
            memreq_q    <= memreq_d;
            busy_q      <= busy_d;
        end
    end

    assign memReq        = memreq_q;
    assign memAdr        = adr_q;
    assign memWr         = wr_q;
    assign memWrData     = wdat_q;
    assign cacheDataRead = rdata_q;
    assign mboxRespIn    = resp_q;
    assign cshEBOXRetry  = retry_pls_q;
    assign mbParErr      = parerr_q;
    assign nxmErr        = nxm_q;
    assign mboxBusy      = busy_q;

endmodule

// File: tb/tb_ebox_mbox_req.sv
// ----------------------------------------------------------------------------
// tb_ebox_mbox_req
// Self-checking bench for ebox_mbox_req. The bench plays both the EBOX and
// an MBOX whose behaviour per transaction is set by (ack delay, read delay,
// number of bad-parity replies, no-ack). Expected latency, memReq cycles,
// retries, error pulses and returned data are computed from those numbers.
// ----------------------------------------------------------------------------
module tb_ebox_mbox_req;

    localparam int TO = 64;
    localparam int RM = 3;

    logic         eboxClk = 1'b0;
    logic         eboxResetN;
    logic         EBOX_REQ;
    logic [13:35] EBOX_VMA;
    logic         eboxRead;
    logic         eboxWrite;
    logic         eboxPSE;
    logic [0:35]  cacheDataWrite;
    logic         memAck;
    logic         memRdValid;
    logic [0:35]  memRdData;
    logic         memRdParErr;
    logic         memReq;
    logic [13:35] memAdr;
    logic         memWr;
    logic [0:35]  memWrData;
    logic [0:35]  cacheDataRead;
    logic         mboxRespIn;
    logic         cshEBOXRetry;
    logic         mbParErr;
    logic         nxmErr;
    logic         mboxBusy;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [35:0]  exp_rdata = 36'd0;

    ebox_mbox_req #(
        .TIMEOUT_CYC (TO),
        .RETRY_MAX   (RM)
    ) dut (
        .eboxClk        (eboxClk),
        .eboxResetN     (eboxResetN),
        .EBOX_REQ       (EBOX_REQ),
        .EBOX_VMA       (EBOX_VMA),
        .eboxRead       (eboxRead),
        .eboxWrite      (eboxWrite),
        .eboxPSE        (eboxPSE),
        .cacheDataWrite (cacheDataWrite),
        .memAck         (memAck),
        .memRdValid     (memRdValid),
        .memRdData      (memRdData),
        .memRdParErr    (memRdParErr),
        .memReq         (memReq),
        .memAdr         (memAdr),
        .memWr          (memWr),
        .memWrData      (memWrData),
        .cacheDataRead  (cacheDataRead),
        .mboxRespIn     (mboxRespIn),
        .cshEBOXRetry   (cshEBOXRetry),
        .mbParErr       (mbParErr),
        .nxmErr         (nxmErr),
        .mboxBusy       (mboxBusy)
    );

    always #5 eboxClk = ~eboxClk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One EBOX request plus the MBOX side of its handshake.
    task automatic run_txn(input string tag, input bit wr, input logic [22:0] vma,
                           input logic [22:0] exp_adr, input logic [35:0] wd,
                           input logic [35:0] rbase, input int d, input bit noack,
                           input int v, input int nerr, input bit pse, input bit spur);
        int cyc, resp_at, resp_n, req_n, retry_n, par_n, nxm_n;
        int req_run, rd_wait, reply_idx, n_att, exp_resp, exp_req;
        bit exp_nxm, exp_par, adr_ok, wr_ok, coinc_ok;

        // Reference expectations.
        exp_nxm = 1'b0;
        exp_par = 1'b0;
        n_att   = 1;
        if (noack) begin
            exp_nxm  = 1'b1;
            exp_resp = TO + 1;
            exp_req  = TO;
        end else if (wr) begin
            exp_resp = d + 2;
            exp_req  = d + 1;
        end else begin
            n_att     = (nerr > RM) ? RM + 1 : nerr + 1;
            exp_par   = (nerr > RM);
            exp_resp  = 1 + n_att * (d + v + 2);
            exp_req   = n_att * (d + 1);
            exp_rdata = rbase + 36'(n_att - 1);
        end

        // Cycle 0: present the request.
        @(negedge eboxClk);
        EBOX_REQ       = 1'b1;
        EBOX_VMA       = vma;
        eboxRead       = !wr;
        eboxWrite      = wr;
        eboxPSE        = pse;
        cacheDataWrite = wd;
        memAck         = 1'b0;
        memRdValid     = 1'b0;
        memRdParErr    = 1'b0;

        cyc = 0; resp_at = -1; resp_n = 0; req_n = 0; retry_n = 0; par_n = 0; nxm_n = 0;
        req_run = 0; rd_wait = -1; reply_idx = 0;
        adr_ok = 1'b1; wr_ok = 1'b1; coinc_ok = 1'b1;

        while (cyc < 400 && (resp_at < 0 || cyc < resp_at + 2)) begin
            @(negedge eboxClk);
            cyc++;
            // Observe this cycle's outputs.
            if (memReq) begin
                req_n++;
                if (memAdr !== exp_adr) adr_ok = 1'b0;
                if (memWr !== wr) wr_ok = 1'b0;
                if (wr && (memWrData !== wd)) wr_ok = 1'b0;
            end
            if (cshEBOXRetry) retry_n++;
            if (nxmErr) begin
                nxm_n++;
                if (!mboxRespIn) coinc_ok = 1'b0;
            end
            if (mbParErr) begin
                par_n++;
                if (!mboxRespIn) coinc_ok = 1'b0;
            end
            if (mboxRespIn) begin
                resp_n++;
                if (resp_at < 0) resp_at = cyc;
            end
            // EBOX: stray requests while busy must be ignored.
            EBOX_REQ       = mboxBusy ? 1'($urandom_range(0, 1)) : 1'b0;
            EBOX_VMA       = 23'($urandom);
            eboxRead       = 1'($urandom_range(0, 1));
            eboxWrite      = 1'($urandom_range(0, 1));
            eboxPSE        = 1'($urandom_range(0, 1));
            cacheDataWrite = {4'($urandom), 32'($urandom)};
            // MBOX responder.
            memAck      = 1'b0;
            memRdValid  = 1'b0;
            memRdParErr = 1'b0;
            memRdData   = {4'($urandom), 32'($urandom)};
            if (rd_wait >= 0) begin
                memAck = spur;
                if (rd_wait == 0) begin
                    memRdValid  = 1'b1;
                    memRdParErr = (reply_idx < nerr);
                    memRdData   = rbase + 36'(reply_idx);
                    reply_idx++;
                    rd_wait = -1;
                end else begin
                    rd_wait--;
                end
            end else if (memReq) begin
                if (!noack && req_run == d) begin
                    memAck  = 1'b1;
                    req_run = 0;
                    if (!wr) rd_wait = v;
                end else begin
                    req_run++;
                end
            end
        end
        EBOX_REQ   = 1'b0;
        memAck     = 1'b0;
        memRdValid = 1'b0;

        chk_eq($sformatf("%s.resp_count", tag), 64'(resp_n), 64'(1));
        chk_eq($sformatf("%s.resp_cycle", tag), 64'(resp_at), 64'(exp_resp));
        chk_eq($sformatf("%s.req_cycles", tag), 64'(req_n), 64'(exp_req));
        chk_eq($sformatf("%s.retries", tag), 64'(retry_n), 64'(n_att - 1));
        chk_eq($sformatf("%s.nxm", tag), 64'(nxm_n), 64'(exp_nxm));
        chk_eq($sformatf("%s.parerr", tag), 64'(par_n), 64'(exp_par));
        chk_eq($sformatf("%s.adr", tag), 64'(adr_ok), 64'(1));
        chk_eq($sformatf("%s.wr", tag), 64'(wr_ok), 64'(1));
        chk_eq($sformatf("%s.coincident", tag), 64'(coinc_ok), 64'(1));
        chk_eq($sformatf("%s.rdata", tag), 64'(cacheDataRead), 64'(exp_rdata));
        chk_eq($sformatf("%s.busy_after", tag), 64'(mboxBusy), 64'(0));
        chk_eq($sformatf("%s.req_after", tag), 64'(memReq), 64'(0));
    endtask

    initial begin
        int resp_n;
        bit rw;
        logic [22:0] va;

        eboxResetN     = 1'b0;
        EBOX_REQ       = 1'b0;
        EBOX_VMA       = '0;
        eboxRead       = 1'b0;
        eboxWrite      = 1'b0;
        eboxPSE        = 1'b0;
        cacheDataWrite = '0;
        memAck         = 1'b0;
        memRdValid     = 1'b0;
        memRdData      = '0;
        memRdParErr    = 1'b0;

        repeat (3) @(negedge eboxClk);
        chk_eq("reset.memReq", 64'(memReq), 64'(0));
        chk_eq("reset.busy", 64'(mboxBusy), 64'(0));
        chk_eq("reset.resp", 64'(mboxRespIn), 64'(0));
        chk_eq("reset.rdata", 64'(cacheDataRead), 64'(0));
        chk_eq("reset.adr", 64'(memAdr), 64'(0));
        eboxResetN = 1'b1;
        @(negedge eboxClk);

        // Directed cases.
        run_txn("rd_basic", 1'b0, 23'o1234567, 23'o1234567, 36'd0, 36'o123456654321, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        run_txn("wr_basic", 1'b1, 23'o40, 23'o40, 36'o777777000000, 36'd0, 4, 1'b0, 0, 0, 1'b0, 1'b0);
        run_txn("rd_retry2", 1'b0, 23'o555, 23'o555, 36'd0, 36'o100, 1, 1'b0, 1, 2, 1'b0, 1'b1);
        run_txn("rd_parerr", 1'b0, 23'o666, 23'o666, 36'd0, 36'o7000, 0, 1'b0, 2, 4, 1'b0, 1'b0);
        run_txn("wr_nxm", 1'b1, 23'o77, 23'o77, 36'o12, 36'd0, 0, 1'b1, 0, 0, 1'b0, 1'b0);
        run_txn("wr_ack64", 1'b1, 23'o76, 23'o76, 36'o13, 36'd0, TO - 1, 1'b0, 0, 0, 1'b0, 1'b0);
        run_txn("rd_nxm", 1'b0, 23'o75, 23'o75, 36'd0, 36'd0, 0, 1'b1, 0, 0, 1'b0, 1'b0);
        run_txn("rd_ack64", 1'b0, 23'o74, 23'o74, 36'd0, 36'o4242, TO - 1, 1'b0, 0, 0, 1'b0, 1'b0);

        // Read-pause-write: write goes to the paused address.
        run_txn("rpw_rd", 1'b0, 23'o1111, 23'o1111, 36'd0, 36'o31415, 1, 1'b0, 0, 0, 1'b1, 1'b0);
        repeat (2) @(negedge eboxClk);
        chk_eq("pause.busy", 64'(mboxBusy), 64'(0));
        chk_eq("pause.adr", 64'(memAdr), 64'(23'o1111));
        run_txn("rpw_wr", 1'b1, 23'o2222, 23'o1111, 36'o525252, 36'd0, 2, 1'b0, 0, 0, 1'b0, 1'b0);

        // A read during PAUSE abandons it and uses the new address.
        run_txn("abn_rd1", 1'b0, 23'o3333, 23'o3333, 36'd0, 36'o11, 0, 1'b0, 0, 0, 1'b1, 1'b0);
        run_txn("abn_rd2", 1'b0, 23'o4444, 23'o4444, 36'd0, 36'o22, 0, 1'b0, 1, 0, 1'b0, 1'b0);

        // Randomized transactions.
        for (int i = 0; i < 16; i++) begin
            rw = 1'($urandom_range(0, 1));
            va = 23'($urandom);
            run_txn($sformatf("rnd%0d", i), rw, va, va, {4'($urandom), 32'($urandom)},
                    {4'($urandom), 32'($urandom)}, int'($urandom_range(0, 6)), 1'b0,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 1'b0,
                    1'($urandom_range(0, 1)));
        end

        // Reset in the middle of ISSUE: outputs clear at once, no response.
        @(negedge eboxClk);
        EBOX_REQ  = 1'b1;
        EBOX_VMA  = 23'o7070;
        eboxRead  = 1'b1;
        eboxWrite = 1'b0;
        eboxPSE   = 1'b0;
        @(negedge eboxClk);
        EBOX_REQ = 1'b0;
        @(negedge eboxClk);
        chk_eq("rst_mid.req_before", 64'(memReq), 64'(1));
        #2;
        eboxResetN = 1'b0;
        #1;
        chk_eq("rst_mid.req", 64'(memReq), 64'(0));
        chk_eq("rst_mid.busy", 64'(mboxBusy), 64'(0));
        chk_eq("rst_mid.adr", 64'(memAdr), 64'(0));
        chk_eq("rst_mid.rdata", 64'(cacheDataRead), 64'(0));
        exp_rdata = 36'd0;
        @(negedge eboxClk);
        eboxResetN = 1'b1;
        resp_n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge eboxClk);
            if (mboxRespIn || memReq) resp_n++;
        end
        chk_eq("rst_mid.no_resp", 64'(resp_n), 64'(0));

        // Normal operation resumes after reset.
        run_txn("post_rst", 1'b0, 23'o123, 23'o123, 36'd0, 36'o707070, 2, 1'b0, 1, 1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
